// File: rtl/div_unit_pkg.sv
// Shared constants for the EX-stage divider: FSM encodings, ALU op codes
// for DIV/DIVU and the HI/LO write-enable mask used by writeback.
package div_unit_pkg;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_CALC = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;

  // R-type funct codes that route an instruction to this unit.
  localparam logic [5:0] ALU_OP_DIV  = 6'h1a;
  localparam logic [5:0] ALU_OP_DIVU = 6'h1b;

  // Writeback mask: bit 1 = HI (remainder), bit 0 = LO (quotient).
  localparam logic [1:0] HILO_WE_NONE = 2'b00;
  localparam logic [1:0] HILO_WE_BOTH = 2'b11;

endpackage

// File: rtl/div_unit_abs.sv
// Conditional two's-complement negate; used for operand magnitudes and for
// applying the quotient/remainder signs once the unsigned division is done.
module div_abs #(
  parameter int WIDTH = 32
) (
  input  logic             neg_i,
  input  logic [WIDTH-1:0] val_i,
  output logic [WIDTH-1:0] val_o
);

  assign val_o = neg_i ? ('0 - val_i) : val_i;

endmodule

// File: rtl/div_unit.sv
// Radix-2 restoring divider (one quotient bit per cycle) for DIV/DIVU.
// Optional macro DIV_EARLY_TERM_EN: finish at once when |dividend| < |divisor|.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic             cancel_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             result_valid_o,
  output logic             busy_o,
  output logic             stall_o,
  output logic             div_zero_o
);

  // Handshake: start_i is a request level; it is accepted only in DIV_IDLE
  // with cancel_i low. result_valid_o pulses for exactly one cycle when the
  // outputs change, and the outputs then hold until the next result.

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             valid_q, valid_d;
  logic             div_zero_q, div_zero_d;

  logic             dvd_neg, dsr_neg;
  logic [WIDTH-1:0] dvd_mag, dsr_mag;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  logic             accept;
  logic             divisor_zero;
  logic             early_term;
  logic [WIDTH:0]   shift_rem;
  logic [WIDTH:0]   trial;

  assign dvd_neg = signed_i & dividend_i[WIDTH-1];
  assign dsr_neg = signed_i & divisor_i[WIDTH-1];

  div_abs #(.WIDTH(WIDTH)) u_abs_dvd (.neg_i(dvd_neg), .val_i(dividend_i), .val_o(dvd_mag));
  div_abs #(.WIDTH(WIDTH)) u_abs_dsr (.neg_i(dsr_neg), .val_i(divisor_i),  .val_o(dsr_mag));
  div_abs #(.WIDTH(WIDTH)) u_fix_quo (.neg_i(q_neg_q), .val_i(quo_q),      .val_o(quo_fix));
  div_abs #(.WIDTH(WIDTH)) u_fix_rem (.neg_i(r_neg_q), .val_i(rem_q),      .val_o(rem_fix));

  assign accept       = (state_q == DIV_IDLE) & start_i & ~cancel_i;
  assign divisor_zero = (divisor_i == '0);

`ifdef DIV_EARLY_TERM_EN
  assign early_term = ~divisor_zero & (dvd_mag < dsr_mag);
`else
  assign early_term = 1'b0;
`endif

  // quo_q starts as the dividend magnitude and is shifted out from the top
  // while quotient bits shift in at the bottom.
  assign shift_rem = {rem_q, quo_q[WIDTH-1]};
  assign trial     = shift_rem - {1'b0, dsr_q};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dsr_d       = dsr_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    valid_d     = 1'b0;
    div_zero_d  = div_zero_q;

    case (state_q)
      DIV_IDLE: begin
        if (accept) begin
          div_zero_d = divisor_zero;
          if (divisor_zero) begin
            // Results are final already; clear the signs so DONE passes them through.
            quo_d   = '1;
            rem_d   = dividend_i;
            q_neg_d = 1'b0;
            r_neg_d = 1'b0;
            state_d = DIV_DONE;
          end else if (early_term) begin
            quo_d   = '0;
            rem_d   = dividend_i;
            q_neg_d = 1'b0;
            r_neg_d = 1'b0;
            state_d = DIV_DONE;
          end else begin
            quo_d   = dvd_mag;
            rem_d   = '0;
            dsr_d   = dsr_mag;
            q_neg_d = dvd_neg ^ dsr_neg;
            r_neg_d = dvd_neg;
            cnt_d   = CNT_W'(WIDTH);
            state_d = DIV_CALC;
          end
        end
      end

      DIV_CALC: begin
        if (cancel_i) begin
          state_d = DIV_IDLE;
        end else begin
          if (!trial[WIDTH]) begin
            rem_d = trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = shift_rem[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = DIV_DONE;
          end
        end
      end

      DIV_DONE: begin
        if (!cancel_i) begin
          quotient_d  = quo_fix;
          remainder_d = rem_fix;
          valid_d     = 1'b1;
        end
        state_d = DIV_IDLE;
      end

      default: begin
        state_d = DIV_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= DIV_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dsr_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      valid_q     <= 1'b0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dsr_q       <= dsr_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      valid_q     <= valid_d;
      div_zero_q  <= div_zero_d;
    end
  end

  assign quotient_o     = quotient_q;
  assign remainder_o    = remainder_q;
  assign result_valid_o = valid_q;
  assign busy_o         = (state_q == DIV_CALC) | (state_q == DIV_DONE);
  // Low in DONE so EX advances on the result cycle.
  assign stall_o        = accept | (state_q == DIV_CALC);
  assign div_zero_o     = div_zero_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: vector table plus hand-written cancel/reset
// sequences. Latency is counted in clock edges after the accept edge.
module tb_div_unit;

  localparam int W = 32;
  localparam int LAT_FULL = W + 1;
`ifdef DIV_EARLY_TERM_EN
  localparam int LAT_ET = 1;
  localparam int STALL_ET = 1;
`else
  localparam int LAT_ET = W + 1;
  localparam int STALL_ET = W + 1;
`endif
  localparam int NV = 15;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_i, signed_i, cancel_i;
  logic [W-1:0] dividend_i, divisor_i;
  logic [W-1:0] quotient_o, remainder_o;
  logic         result_valid_o, busy_o, stall_o, div_zero_o;

  always #5 clk = ~clk;

  div_unit #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .signed_i      (signed_i),
    .cancel_i      (cancel_i),
    .dividend_i    (dividend_i),
    .divisor_i     (divisor_i),
    .quotient_o    (quotient_o),
    .remainder_o   (remainder_o),
    .result_valid_o(result_valid_o),
    .busy_o        (busy_o),
    .stall_o       (stall_o),
    .div_zero_o    (div_zero_o)
  );

  typedef struct {
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           lat;
    int           stalls;
  } vec_t;

  vec_t vecs [NV];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Called with inputs free to change (just after a posedge).
  task automatic run_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int stalls);
    signed_i = sgn; dividend_i = a; divisor_i = b; start_i = 1'b1;
    stalls = 0; lat = -1;
    #1;
    if (stall_o) stalls++;
    @(posedge clk); #1;
    start_i = 1'b0; dividend_i = ~a; divisor_i = ~b;
    if (stall_o) stalls++;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (result_valid_o) begin
        lat = k;
        break;
      end
      if (stall_o) stalls++;
    end
  endtask

  task automatic run_vec(input int i, input vec_t v);
    int lat, stalls;
    run_op(v.sgn, v.a, v.b, lat, stalls);
    check($sformatf("v%0d_latency", i), W'(lat), W'(v.lat));
    check($sformatf("v%0d_quotient", i), quotient_o, v.q);
    check($sformatf("v%0d_remainder", i), remainder_o, v.r);
    check($sformatf("v%0d_div_zero", i), W'(div_zero_o), W'(v.dz));
    check($sformatf("v%0d_stall_cycles", i), W'(stalls), W'(v.stalls));
    @(posedge clk); #1;
    check($sformatf("v%0d_valid_pulse_end", i), W'(result_valid_o), '0);
    check($sformatf("v%0d_idle_after", i), W'(busy_o), '0);
  endtask

  initial begin
    logic [W-1:0] prev_q, prev_r;
    logic         valid_seen;
    int           lat, stalls;

    //                 sgn   a             b             q             r             dz    lat       stalls
    vecs[0]  = '{1'b0, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0, LAT_FULL, W + 1};
    vecs[1]  = '{1'b1, -32'sd7,      32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, LAT_FULL, W + 1};
    vecs[2]  = '{1'b1, 32'd7,        -32'sd2,      32'hFFFFFFFD, 32'd1,        1'b0, LAT_FULL, W + 1};
    vecs[3]  = '{1'b0, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        1'b1, 1,        1};
    vecs[4]  = '{1'b0, 32'd9,        32'd3,        32'd3,        32'd0,        1'b0, LAT_FULL, W + 1};
    vecs[5]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, LAT_FULL, W + 1};
    vecs[6]  = '{1'b0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b0, LAT_FULL, W + 1};
    vecs[7]  = '{1'b0, 32'd3,        32'd10,       32'd0,        32'd3,        1'b0, LAT_ET,   STALL_ET};
    vecs[8]  = '{1'b1, -32'sd3,      32'd10,       32'd0,        32'hFFFFFFFD, 1'b0, LAT_ET,   STALL_ET};
    vecs[9]  = '{1'b0, 32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF, 32'hF,        1'b0, LAT_FULL, W + 1};
    vecs[10] = '{1'b1, -32'sd100,    -32'sd7,      32'd14,       32'hFFFFFFFE, 1'b0, LAT_FULL, W + 1};
    vecs[11] = '{1'b0, 32'd7,        32'd7,        32'd1,        32'd0,        1'b0, LAT_FULL, W + 1};
    vecs[12] = '{1'b1, -32'sd5,      32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1, 1,        1};
    vecs[13] = '{1'b0, 32'd0,        32'd5,        32'd0,        32'd0,        1'b0, LAT_ET,   STALL_ET};
    vecs[14] = '{1'b0, 32'h80000000, 32'h80000000, 32'd1,        32'd0,        1'b0, LAT_FULL, W + 1};

    rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; cancel_i = 1'b0;
    dividend_i = '0; divisor_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_quotient", quotient_o, '0);
    check("reset_remainder", remainder_o, '0);
    check("reset_valid", W'(result_valid_o), '0);
    check("reset_busy", W'(busy_o), '0);
    check("reset_div_zero", W'(div_zero_o), '0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // Cancel mid-CALC, with an ignored start while busy.
    prev_q = quotient_o; prev_r = remainder_o; valid_seen = 1'b0;
    signed_i = 1'b0; dividend_i = 32'd1000; divisor_i = 32'd3; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      valid_seen |= result_valid_o;
      if (k == 4) begin start_i = 1'b1; dividend_i = 32'd50; divisor_i = 32'd5; end
      if (k == 5) begin
        start_i = 1'b0;
        check("busy_after_ignored_start", W'(busy_o), W'(1));
      end
      if (k == 9) cancel_i = 1'b1;
      if (k == 10) cancel_i = 1'b0;
    end
    check("cancel_busy", W'(busy_o), '0);
    check("cancel_stall", W'(stall_o), '0);
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      valid_seen |= result_valid_o;
    end
    check("cancel_no_valid", W'(valid_seen), '0);
    check("cancel_quotient_held", quotient_o, prev_q);
    check("cancel_remainder_held", remainder_o, prev_r);

    run_op(1'b0, 32'd1000, 32'd3, lat, stalls);
    check("after_cancel_latency", W'(lat), W'(LAT_FULL));
    check("after_cancel_quotient", quotient_o, 32'd333);
    check("after_cancel_remainder", remainder_o, 32'd1);
    @(posedge clk); #1;

    // Cancel and start together in IDLE: cancel wins.
    start_i = 1'b1; cancel_i = 1'b1; dividend_i = 32'd20; divisor_i = 32'd4;
    #1;
    check("start_cancel_stall", W'(stall_o), '0);
    @(posedge clk); #1;
    start_i = 1'b0; cancel_i = 1'b0;
    check("start_cancel_busy", W'(busy_o), '0);
    check("start_cancel_quotient", quotient_o, 32'd333);

    // Cancel while in DONE (divide-by-zero path reaches DONE after one edge).
    prev_q = quotient_o; prev_r = remainder_o; valid_seen = 1'b0;
    dividend_i = 32'd5; divisor_i = 32'd0; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    check("done_busy", W'(busy_o), W'(1));
    check("done_stall_low", W'(stall_o), '0);
    cancel_i = 1'b1;
    @(posedge clk); #1;
    cancel_i = 1'b0;
    valid_seen |= result_valid_o;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      valid_seen |= result_valid_o;
    end
    check("done_cancel_no_valid", W'(valid_seen), '0);
    check("done_cancel_quotient_held", quotient_o, prev_q);
    check("done_cancel_remainder_held", remainder_o, prev_r);
    check("done_cancel_busy", W'(busy_o), '0);

    // Synchronous reset in the middle of CALC.
    signed_i = 1'b0; dividend_i = 32'd100; divisor_i = 32'd7; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
    end
    check("pre_reset_busy", W'(busy_o), W'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midcalc_reset_quotient", quotient_o, '0);
    check("midcalc_reset_remainder", remainder_o, '0);
    check("midcalc_reset_busy", W'(busy_o), '0);
    check("midcalc_reset_stall", W'(stall_o), '0);
    check("midcalc_reset_div_zero", W'(div_zero_o), '0);
    check("midcalc_reset_valid", W'(result_valid_o), '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
